// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: req/ack instruction fetch with a prefetch FIFO and a valid/ready decode handoff
module ifetch_prefetch_unit #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    oMemReq,
    output logic [ADDR_W-1:0]       oMemAddr,
    input  logic                    iMemAck,
    input  logic [INST_W-1:0]       iMemData,
    input  logic                    iRedirect,
    input  logic [ADDR_W-1:0]       iRedirectPC,
    output logic                    oInstValid,
    output logic [INST_W-1:0]       oInst,
    output logic [ADDR_W-1:0]       oInstPC,
    output logic [ADDR_W-1:0]       oInstPC4,
    input  logic                    iInstReady,
    output logic [$clog2(DEPTH):0]  oLevel
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [INST_W-1:0] instMem [DEPTH];
    logic [ADDR_W-1:0] pcMem [DEPTH];
    logic [PW-1:0]     rdPtr, wrPtr;
    logic [LW-1:0]     levelNext;
    logic [ADDR_W-1:0] fetchPC, fetchPCNext, redirectPC;
    logic              discard, ack, push, pop, holdReq, issue;
    logic              unusedBits;

    assign unusedBits = ^iRedirectPC[1:0];

    // Handshake decode; a request stays outstanding until acked, and only then may a new one (owning a slot) be issued
    always_comb begin
        ack = iMemAck & oMemReq;
        push = ack & !discard & !iRedirect;
        pop = oInstValid & iInstReady & !iRedirect;
        holdReq = oMemReq & !ack;
        redirectPC = {iRedirectPC[ADDR_W-1:2], 2'b00};
        levelNext = iRedirect ? '0 : oLevel + LW'(push) - LW'(pop);
        fetchPCNext = iRedirect ? redirectPC : push ? fetchPC + ADDR_W'(4) : fetchPC;
        issue = !holdReq & (levelNext < LW'(DEPTH));
    end

    // Control state: fetch pointer, request port, discard flag and FIFO bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetchPC <= RESET_PC;
            oMemReq <= 1'b0;
            oMemAddr <= RESET_PC;
            discard <= 1'b0;
            oLevel <= '0;
            oInstValid <= 1'b0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            fetchPC <= fetchPCNext;
            oMemReq <= issue | holdReq;
            oMemAddr <= issue ? fetchPCNext : oMemAddr;
            discard <= holdReq & (iRedirect | discard);
            oLevel <= levelNext;
            oInstValid <= levelNext != '0;
            rdPtr <= iRedirect ? '0 : rdPtr + PW'(pop);
            wrPtr <= iRedirect ? '0 : wrPtr + PW'(push);
        end
    end

    // FIFO storage keeps each word with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtr] <= iMemData;
            pcMem[wrPtr] <= oMemAddr;
        end
    end

    // Head presentation, zeroed while the FIFO is empty
    always_comb begin
        oInst = oInstValid ? instMem[rdPtr] : '0;
        oInstPC = oInstValid ? pcMem[rdPtr] : '0;
        oInstPC4 = oInstValid ? pcMem[rdPtr] + ADDR_W'(4) : '0;
    end
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb_ifetch_prefetch_unit: vector table, corner sequences and randomized run against a queue model
module tb_ifetch_prefetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        oMemReq;
    logic [31:0] oMemAddr;
    logic        iMemAck = 1'b0;
    logic [31:0] iMemData = '0;
    logic        iRedirect = 1'b0;
    logic [31:0] iRedirectPC = '0;
    logic        oInstValid;
    logic [31:0] oInst;
    logic [31:0] oInstPC;
    logic [31:0] oInstPC4;
    logic        iInstReady = 1'b0;
    logic [2:0]  oLevel;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    bit          mReq, mDisc;
    logic [31:0] mAddr, mPC;

    typedef struct {
        bit          rst;
        bit          ack;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        int          lvl;
        bit          vld;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[12];

    ifetch_prefetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .resetn(resetn),
        .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck), .iMemData(iMemData),
        .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
        .oInstValid(oInstValid), .oInst(oInst), .oInstPC(oInstPC), .oInstPC4(oInstPC4),
        .iInstReady(iInstReady), .oLevel(oLevel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instOf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mReq = 0;
        mDisc = 0;
        mAddr = 32'h0;
        mPC = 32'h0;
    endtask

    // One clock edge of the fetch unit, stated as queue operations
    task automatic modelStep(input bit ack, input bit rdy, input bit red, input logic [31:0] tgt);
        bit hadHead;
        bit done;
        hadHead = mq.size() != 0;
        done = ack && mReq;
        if (red) begin
            mq.delete();
            mPC = {tgt[31:2], 2'b00};
            if (mReq && !ack) mDisc = 1;
            else begin
                mDisc = 0;
                mReq = 1;
                mAddr = mPC;
            end
        end else begin
            if (hadHead && rdy) void'(mq.pop_front());
            if (done) begin
                if (mDisc) mDisc = 0;
                else begin
                    mq.push_back(mAddr);
                    mPC = mPC + 32'd4;
                end
                mReq = 0;
            end
            if (!mReq && mq.size() < DEPTH) begin
                mReq = 1;
                mAddr = mPC;
            end
        end
    endtask

    task automatic cmpModel();
        bit          v;
        logic [31:0] hp;
        v = mq.size() != 0;
        hp = v ? mq[0] : 32'h0;
        check("m_req", oMemReq, mReq);
        check("m_addr", oMemAddr, mAddr);
        check("m_level", oLevel, mq.size());
        check("m_valid", oInstValid, v);
        check("m_inst", oInst, v ? instOf(hp) : 32'h0);
        check("m_pc", oInstPC, hp);
        check("m_pc4", oInstPC4, v ? hp + 32'd4 : 32'h0);
    endtask

    // Drive inputs at the falling edge, advance the model at the rising edge, compare at the next falling edge
    task automatic cyc(input bit ack, input bit rdy, input bit red, input logic [31:0] tgt);
        iMemAck = ack;
        iInstReady = rdy;
        iRedirect = red;
        iRedirectPC = tgt;
        iMemData = instOf(mAddr);
        @(posedge clk);
        modelStep(ack, rdy, red, tgt);
        @(negedge clk);
        cmpModel();
    endtask

    task automatic doReset();
        resetn = 0;
        iMemAck = 0;
        iInstReady = 0;
        iRedirect = 0;
        iRedirectPC = '0;
        iMemData = '0;
        modelReset();
        #1;
        check("rst_req", oMemReq, 0);
        check("rst_addr", oMemAddr, 32'h0);
        check("rst_level", oLevel, 0);
        check("rst_valid", oInstValid, 0);
        check("rst_inst", oInst, 32'h0);
        check("rst_pc", oInstPC, 32'h0);
        check("rst_pc4", oInstPC4, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        int delivered;
        logic [31:0] expDeliv;
        bit rAck, rRdy, rRed;
        logic [31:0] rTgt;
        #1;
        tbl[0]  = '{1, 1, 1, 1, 32'h00, 0, 0, 32'h0};
        tbl[1]  = '{0, 1, 1, 1, 32'h04, 1, 1, 32'h0};
        tbl[2]  = '{0, 1, 1, 1, 32'h08, 1, 1, 32'h4};
        tbl[3]  = '{0, 1, 1, 1, 32'h0C, 1, 1, 32'h8};
        tbl[4]  = '{1, 1, 0, 1, 32'h00, 0, 0, 32'h0};
        tbl[5]  = '{0, 1, 0, 1, 32'h04, 1, 1, 32'h0};
        tbl[6]  = '{0, 1, 0, 1, 32'h08, 2, 1, 32'h0};
        tbl[7]  = '{0, 1, 0, 1, 32'h0C, 3, 1, 32'h0};
        tbl[8]  = '{0, 1, 0, 0, 32'h0C, 4, 1, 32'h0};
        tbl[9]  = '{0, 1, 0, 0, 32'h0C, 4, 1, 32'h0};
        tbl[10] = '{0, 1, 1, 1, 32'h10, 3, 1, 32'h4};
        tbl[11] = '{0, 1, 0, 0, 32'h10, 4, 1, 32'h4};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) doReset();
            cyc(tbl[i].ack, tbl[i].rdy, 0, 32'h0);
            check("tbl_req", oMemReq, tbl[i].req);
            check("tbl_addr", oMemAddr, tbl[i].addr);
            check("tbl_level", oLevel, tbl[i].lvl);
            check("tbl_valid", oInstValid, tbl[i].vld);
            check("tbl_pc", oInstPC, tbl[i].pc);
            check("tbl_pc4", oInstPC4, tbl[i].vld ? tbl[i].pc + 32'd4 : 32'h0);
            check("tbl_inst", oInst, tbl[i].vld ? instOf(tbl[i].pc) : 32'h0);
        end

        // slow memory: each request held stable until its third cycle
        doReset();
        cyc(0, 1, 0, 32'h0);
        delivered = 0;
        expDeliv = 32'h0;
        for (int k = 0; k < 5; k++) begin
            for (int w = 0; w < 2; w++) begin
                cyc(0, 1, 0, 32'h0);
                check("slow_req", oMemReq, 1);
                check("slow_addr", oMemAddr, k * 4);
                if (oInstValid) begin
                    check("slow_order", oInstPC, expDeliv);
                    expDeliv = expDeliv + 32'd4;
                    delivered++;
                end
            end
            cyc(1, 1, 0, 32'h0);
            if (oInstValid) begin
                check("slow_order", oInstPC, expDeliv);
                expDeliv = expDeliv + 32'd4;
                delivered++;
            end
        end
        check("slow_count", delivered, 5);

        // redirect while a request is pending without ack
        doReset();
        cyc(0, 0, 0, 32'h0);
        cyc(1, 0, 0, 32'h0);
        cyc(1, 0, 0, 32'h0);
        cyc(0, 0, 1, 32'h40);
        check("redir_level", oLevel, 0);
        check("redir_valid", oInstValid, 0);
        check("redir_hold_addr", oMemAddr, 32'h8);
        check("redir_hold_req", oMemReq, 1);
        cyc(0, 0, 0, 32'h0);
        check("redir_hold_addr2", oMemAddr, 32'h8);
        cyc(1, 0, 0, 32'h0);
        check("redir_drop_level", oLevel, 0);
        check("redir_new_addr", oMemAddr, 32'h40);
        cyc(1, 0, 0, 32'h0);
        check("redir_first_pc", oInstPC, 32'h40);

        // redirect coinciding with ack, unaligned target
        cyc(1, 0, 1, 32'h103);
        check("rack_level", oLevel, 0);
        check("rack_req", oMemReq, 1);
        check("rack_addr", oMemAddr, 32'h100);
        cyc(1, 0, 0, 32'h0);
        check("rack_first_pc", oInstPC, 32'h100);
        check("rack_next_addr", oMemAddr, 32'h104);

        // second redirect while the stale request is still outstanding
        cyc(0, 0, 1, 32'h200);
        cyc(0, 0, 1, 32'h300);
        check("dbl_hold_addr", oMemAddr, 32'h104);
        cyc(1, 0, 0, 32'h0);
        check("dbl_addr", oMemAddr, 32'h300);
        cyc(1, 0, 0, 32'h0);
        check("dbl_first_pc", oInstPC, 32'h300);

        // asynchronous reset mid-transaction
        doReset();
        cyc(0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 32'h0);
        check("pre_rst_level", oLevel, 3);
        check("pre_rst_req", oMemReq, 1);
        #2;
        doReset();
        cyc(1, 1, 0, 32'h0);
        check("post_rst_addr", oMemAddr, 32'h0);
        check("post_rst_req", oMemReq, 1);
        cyc(1, 1, 0, 32'h0);
        check("post_rst_pc", oInstPC, 32'h0);

        // randomized traffic against the queue model
        doReset();
        for (int n = 0; n < 3000; n++) begin
            rAck = $urandom_range(0, 2) != 0;
            rRdy = (n % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rRed = $urandom_range(0, 24) == 0;
            rTgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc(rAck, rRdy, rRed, rTgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
